mac_operand_loader: RTL and testbench

Upstream feeder for the fixed-point MAC engine. Accepts a serial valid/ready stream of (A, B) operand pairs and writes them into two J-entry register banks that drive the MAC's parallel operand inputs. Zero-pads short vectors, pulses the MAC start, then holds the banks stable until the MAC reports done before accepting the next vector.

---
 rtl/mac_operand_loader_if.sv | 27 ++
 rtl/mac_operand_loader.sv | 132 +++++++++++++
 tb/tb_mac_operand_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_loader_if.sv
// Operand-pair stream between the upstream source and the MAC operand loader.
// The source drives pairs and the vector marker; the loader drives ready.
interface mac_operand_loader_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_last;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/mac_operand_loader.sv
// Loads serial (A, B) operand pairs into two J-entry banks for the MAC, zero-pads
// short vectors, pulses mac_start and holds the banks until the MAC signals done.
module mac_operand_loader #(
    parameter int unsigned J = 240,
    parameter int unsigned N = 32,
    parameter int unsigned Q = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_operand_loader_if.slave  s_if,
    output logic [N-1:0]         out_a_o [0:J-1],
    output logic [N-1:0]         out_b_o [0:J-1],
    output logic                 mac_start_o,
    input  logic                 mac_done_i,
    output logic                 busy_o,
    output logic [15:0]          batch_cnt_o
);
    localparam int unsigned IdxW    = (J > 1) ? $clog2(J) : 1;
    localparam logic [15:0] LastIdx = 16'(J - 1);

    // Q only documents the operand format; words pass through untouched.
    if (Q >= N) begin : g_bad_q
        $error("Q must be smaller than N");
    end
    if (J < 2 || J > 65536) begin : g_bad_j
        $error("J must lie in 2..65536");
    end

    typedef enum logic [1:0] {StFill, StPad, StStart, StWait} state_e;

    state_e       state_q, state_d;
    logic [15:0]  idx_q, idx_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         done_q;
    logic [N-1:0] bank_a_q [0:J-1];
    logic [N-1:0] bank_b_q [0:J-1];

    logic         bank_we;
    logic [N-1:0] wr_a;
    logic [N-1:0] wr_b;
    logic         ready;
    logic         start;
    logic         busy;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bank_we = 1'b0;
        wr_a    = '0;
        wr_b    = '0;
        ready   = 1'b0;
        start   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StFill: begin
                ready = 1'b1;
                if (s_if.in_valid && !rst) begin
                    bank_we = 1'b1;
                    wr_a    = s_if.in_a;
                    wr_b    = s_if.in_b;
                    if (idx_q == LastIdx) begin
                        state_d = StStart;
                    end else begin
                        idx_d = idx_q + 16'd1;
                        if (s_if.in_last) begin
                            state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                busy    = 1'b1;
                bank_we = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StStart;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            StStart: begin
                busy    = 1'b1;
                start   = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                busy = 1'b1;
                // A done level left over from the previous run must not count.
                if (mac_done_i && !done_q) begin
                    idx_d   = '0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= mac_done_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < J; i++) begin
                bank_a_q[i] <= '0;
                bank_b_q[i] <= '0;
            end
        end else if (bank_we) begin
            bank_a_q[idx_q[IdxW-1:0]] <= wr_a;
            bank_b_q[idx_q[IdxW-1:0]] <= wr_b;
        end
    end

    // Control outputs are forced inactive for the whole reset pulse.
    assign s_if.in_ready = ready & !rst;
    assign mac_start_o   = start & !rst;
    assign busy_o        = busy & !rst;
    assign batch_cnt_o   = cnt_q;
    assign out_a_o       = bank_a_q;
    assign out_b_o       = bank_b_q;
endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed-plus-random bench for mac_operand_loader with a vector-level model
// of bank contents, start timing and batch count.
module tb_mac_operand_loader;
    localparam int unsigned J = 4;
    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mac_done = 1'b0;
    logic [N-1:0] out_a [0:J-1];
    logic [N-1:0] out_b [0:J-1];
    logic         mac_start;
    logic         busy;
    logic [15:0]  batch_cnt;

    mac_operand_loader_if #(.N(N)) bus ();

    mac_operand_loader #(.J(J), .N(N), .Q(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (bus),
        .out_a_o     (out_a),
        .out_b_o     (out_b),
        .mac_start_o (mac_start),
        .mac_done_i  (mac_done),
        .busy_o      (busy),
        .batch_cnt_o (batch_cnt)
    );

    always #5 clk = ~clk;

    int unsigned  total  = 0;
    int unsigned  passed = 0;
    int unsigned  fails  = 0;
    int unsigned  mcnt   = 0;
    logic [N-1:0] ma [J];
    logic [N-1:0] mb [J];
    logic [N-1:0] va [J];
    logic [N-1:0] vb [J];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_banks(input string tag);
        for (int i = 0; i < J; i++) begin
            chk($sformatf("%s out_a[%0d]", tag, i), 64'(out_a[i]), 64'(ma[i]));
            chk($sformatf("%s out_b[%0d]", tag, i), 64'(out_b[i]), 64'(mb[i]));
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < J; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        mcnt = 0;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < J; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
    endtask

    // Streams len pairs (in_last on the final one); bubbles gives valid 1,0,1,0,1,1.
    // Returns in the first WAIT cycle after checking PAD length and the start pulse.
    task automatic push_vector(input int len, input bit bubbles);
        for (int i = 0; i < len; i++) begin
            if (bubbles && (i == 1 || i == 2)) begin
                bus.in_valid = 1'b0;
                bus.in_a     = $urandom;
                bus.in_b     = $urandom;
                bus.in_last  = 1'b1;
                #1;
                chk("ready_in_bubble", 64'(bus.in_ready), 64'd1);
                cyc();
            end
            bus.in_valid = 1'b1;
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            bus.in_last  = (i == len - 1) ? ((len == J) ? 1'($urandom) : 1'b1) : 1'b0;
            #1;
            chk("ready_in_fill", 64'(bus.in_ready), 64'd1);
            chk("start_in_fill", 64'(mac_start), 64'd0);
            cyc();
            ma[i] = va[i];
            mb[i] = vb[i];
        end
        for (int i = len; i < J; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        // Offered pairs during PAD/START must be refused.
        bus.in_valid = 1'b1;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_last  = 1'b0;
        for (int k = 0; k < J - len; k++) begin
            #1;
            chk("ready_in_pad", 64'(bus.in_ready), 64'd0);
            chk("start_in_pad", 64'(mac_start), 64'd0);
            chk("busy_in_pad", 64'(busy), 64'd1);
            cyc();
        end
        chk("start_pulse", 64'(mac_start), 64'd1);
        chk("ready_at_start", 64'(bus.in_ready), 64'd0);
        cyc();
        chk("start_one_cycle", 64'(mac_start), 64'd0);
        chk("ready_in_wait", 64'(bus.in_ready), 64'd0);
        chk("busy_in_wait", 64'(busy), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    // Waits delay cycles in WAIT with junk traffic, then raises done.
    task automatic wait_done(input int delay);
        for (int d = 0; d < delay; d++) begin
            bus.in_valid = 1'($urandom);
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            bus.in_last  = 1'($urandom);
            #1;
            chk("ready_while_wait", 64'(bus.in_ready), 64'd0);
            chk("no_start_while_wait", 64'(mac_start), 64'd0);
            cyc();
        end
        mac_done     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = $urandom;
        #1;
        chk("ready_on_done_rise", 64'(bus.in_ready), 64'd0);
        cyc();
        bus.in_valid = 1'b0;
        mcnt++;
        chk("ready_after_done", 64'(bus.in_ready), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("batch_cnt", 64'(batch_cnt), 64'(16'(mcnt)));
        chk_banks("frozen_in_wait");
        mac_done = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hdead_beef;
        bus.in_b     = 32'hcafe_f00d;
        bus.in_last  = 1'b0;
        model_clear();

        // Reset held for two cycles with a pair offered.
        cyc();
        chk("ready_during_rst", 64'(bus.in_ready), 64'd0);
        chk("start_during_rst", 64'(mac_start), 64'd0);
        chk("busy_during_rst", 64'(busy), 64'd0);
        chk("batch_during_rst", 64'(batch_cnt), 64'd0);
        chk_banks("reset");
        cyc();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
        chk("batch_after_rst", 64'(batch_cnt), 64'd0);

        // Full directed vector, done 10 cycles after start.
        va[0] = 32'h8000;  va[1] = 32'h10000; va[2] = 32'h18000; va[3] = 32'h20000;
        for (int i = 0; i < J; i++) vb[i] = 32'h8000;
        push_vector(4, 1'b0);
        chk_banks("full");
        wait_done(10);

        // Early last after two pairs: two PAD cycles.
        va[0] = 32'h1; va[1] = 32'h2; vb[0] = 32'h11; vb[1] = 32'h22;
        push_vector(2, 1'b0);
        chk_banks("early_last");
        wait_done(2);

        // Stale done held through START and the first WAIT cycle.
        rand_vec();
        mac_done = 1'b1;
        push_vector(4, 1'b0);
        cyc();
        chk("stale_done_ignored", 64'(bus.in_ready), 64'd0);
        mac_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_a     = $urandom;
            #1;
            chk("ready_done_low", 64'(bus.in_ready), 64'd0);
            cyc();
        end
        chk_banks("stale");
        wait_done(0);

        // Backpressure and bubbles.
        rand_vec();
        push_vector(4, 1'b1);
        chk_banks("bubbles");
        wait_done(3);

        // Random vectors.
        for (int r = 0; r < 8; r++) begin
            rand_vec();
            push_vector(int'($urandom_range(1, J)), 1'($urandom));
            chk_banks("random");
            wait_done(int'($urandom_range(0, 6)));
        end

        // Reset during WAIT.
        rand_vec();
        push_vector(3, 1'b0);
        rst = 1'b1;
        #1;
        chk("ready_rst_wait", 64'(bus.in_ready), 64'd0);
        chk("busy_rst_wait", 64'(busy), 64'd0);
        cyc();
        model_clear();
        chk_banks("rst_wait");
        chk("batch_rst_wait", 64'(batch_cnt), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst_wait", 64'(bus.in_ready), 64'd1);

        // Reset after two handshakes in FILL, then a fresh vector.
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            bus.in_last  = 1'b0;
            cyc();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk_banks("rst_fill");
        chk("batch_rst_fill", 64'(batch_cnt), 64'd0);
        chk("ready_rst_fill", 64'(bus.in_ready), 64'd1);
        rand_vec();
        push_vector(4, 1'b0);
        chk_banks("after_reset");
        wait_done(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
